// File: rtl/pulse_send_pkg.sv
// Shared definitions for the toggle request/acknowledge pulse sender.
package pulse_send_pkg;

  // Handshake FSM encoding, shared with the matching receiver.
  typedef enum logic {
    ST_IDLE     = 1'b0,
    ST_WAIT_ACK = 1'b1
  } pulse_state_e;

  localparam int unsigned DEF_CNT_W    = 4;
  localparam int unsigned DEF_SYNC_STG = 2;

endpackage

// File: rtl/pulse_send_sync_ff.sv
// Multi-flop level synchronizer for the acknowledge toggle from the far domain.
module pulse_send_sync_ff #(
  parameter int unsigned P_STG = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic [P_STG-1:0] stg_q;
  logic [P_STG-1:0] stg_d;

  // Shift the asynchronous level one stage deeper each cycle.
  always_comb begin
    stg_d = {stg_q[P_STG-2:0], d_i};
  end

  // Synchronizer chain register; all stages clear on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stg_q <= '0;
    end else begin
      stg_q <= stg_d;
    end
  end

  assign q_o = stg_q[P_STG-1];

endmodule

// File: rtl/pulse_send.sv
// Sending end of a toggle request/acknowledge crossing. Incoming pulses are
// counted; one pending event at a time is launched as a REQ_TGL_O transition
// and is complete once the synchronized ACK level matches REQ_TGL_O.
//
// Handshake: an event is "in flight" from the edge that inverts REQ_TGL_O
// until the edge on which ack_s == REQ_TGL_O is seen in WAIT_ACK; the next
// launch can happen no earlier than the edge after that.
module pulse_send
  import pulse_send_pkg::*;
#(
  parameter int unsigned P_CNT_W    = DEF_CNT_W,
  parameter int unsigned P_SYNC_STG = DEF_SYNC_STG
) (
  input  logic               CLK,
  input  logic               XRST,
  input  logic               PULSE_I,
  output logic               REQ_TGL_O,
  input  logic               ACK_TGL_I,
  output logic [P_CNT_W-1:0] PEND_O,
  output logic               BUSY_O,
  output logic               OVF_O,
  input  logic               OVF_CLR_I,
  output logic               STATE_DBG_O
);

  localparam logic [P_CNT_W-1:0] CNT_MAX = '1;
  localparam logic [P_CNT_W-1:0] CNT_ONE = {{(P_CNT_W-1){1'b0}}, 1'b1};

  pulse_state_e       state_q, state_d;
  logic               req_q, req_d;
  logic [P_CNT_W-1:0] pend_q, pend_d;
  logic               ovf_q, ovf_d;

  logic ack_s;
  logic launch;
  logic accept;
  logic drop;

  pulse_send_sync_ff #(
    .P_STG (P_SYNC_STG)
  ) u_ack_sync (
    .clk   (CLK),
    .rst_n (XRST),
    .d_i   (ACK_TGL_I),
    .q_o   (ack_s)
  );

  // Decide launch/accept/drop for this edge; a launch frees a slot so a
  // saturated counter can still accept a coincident pulse.
  always_comb begin
    launch = 1'b0;
    accept = 1'b0;
    drop   = 1'b0;
    launch = (state_q == ST_IDLE) && (pend_q != '0);
    accept = PULSE_I && ((pend_q != CNT_MAX) || launch);
    drop   = PULSE_I && !accept;
  end

  // Pending counter: accept and launch together cancel out.
  always_comb begin
    pend_d = pend_q;
    if (accept && !launch) begin
      pend_d = pend_q + CNT_ONE;
    end else if (launch && !accept) begin
      pend_d = pend_q - CNT_ONE;
    end
  end

  // Handshake FSM; ack_s is only looked at while waiting.
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    case (state_q)
      ST_IDLE: begin
        if (launch) begin
          req_d   = ~req_q;
          state_d = ST_WAIT_ACK;
        end
      end
      ST_WAIT_ACK: begin
        if (ack_s == req_q) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Sticky overflow; a drop on the same edge as a clear wins.
  always_comb begin
    ovf_d = ovf_q;
    if (drop) begin
      ovf_d = 1'b1;
    end else if (OVF_CLR_I) begin
      ovf_d = 1'b0;
    end
  end

  // State registers; reset discards everything pending or in flight.
  always_ff @(posedge CLK or negedge XRST) begin
    if (!XRST) begin
      state_q <= ST_IDLE;
      req_q   <= 1'b0;
      pend_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      pend_q  <= pend_d;
      ovf_q   <= ovf_d;
    end
  end

  assign REQ_TGL_O   = req_q;
  assign PEND_O      = pend_q;
  assign OVF_O       = ovf_q;
  assign BUSY_O      = (state_q == ST_WAIT_ACK) || (pend_q != '0);
  assign STATE_DBG_O = state_q;

endmodule

// File: doc/pulse_send.md
PULSE_SEND -- requirements
Module: PULSE_SEND

Interface
REQ-001 Parameter P_CNT_W, default 4: width of the pending-pulse counter, legal range 2..8.
REQ-002 Parameter P_SYNC_STG, default 2: number of synchronizer flops on ACK_TGL_I, legal range 2..4.
REQ-003 CLK  input  1  single block clock; all state on its rising edge.
REQ-004 XRST  input  1  reset, asynchronous assert, active-low (0 = reset).
REQ-005 PULSE_I  input  1  single-cycle event request, CLK domain.
REQ-006 REQ_TGL_O  output  1  request toggle level to the far clock domain; one transition per event sent.
REQ-007 ACK_TGL_I  input  1  acknowledge toggle level from the far domain, asynchronous to CLK.
REQ-008 PEND_O  output  P_CNT_W  events accepted but not yet launched.
REQ-009 BUSY_O  output  1  high while any event is pending or in flight.
REQ-010 OVF_O  output  1  sticky flag: an event was dropped.
REQ-011 OVF_CLR_I  input  1  single-cycle clear for OVF_O.

Function
REQ-012 The block SHALL be the sending end of a toggle request/acknowledge protocol; each event is one REQ_TGL_O transition, completed when the synchronized ACK level equals REQ_TGL_O.
REQ-013 ACK_TGL_I SHALL pass through P_SYNC_STG flops before any use; the last stage is ack_s.
REQ-014 The FSM SHALL have two states, IDLE and WAIT_ACK; reset state IDLE.
REQ-015 In IDLE with PEND_O != 0, the block SHALL invert REQ_TGL_O, decrement PEND_O and enter WAIT_ACK on the same edge.
REQ-016 In WAIT_ACK, when ack_s == REQ_TGL_O, the block SHALL return to IDLE; a new launch occurs no earlier than the following edge.
REQ-017 In IDLE, ack_s transitions SHALL be ignored, with no state or output change.
REQ-018 PULSE_I sampled high SHALL increment PEND_O on that edge; with PEND_O = 0 and IDLE, REQ_TGL_O toggles on the next edge (latency 2 edges from sample).
REQ-019 Simultaneous accept and launch SHALL leave PEND_O unchanged.
REQ-020 PEND_O SHALL saturate at 2^P_CNT_W-1; PULSE_I while saturated with no simultaneous launch SHALL be dropped and set OVF_O.
REQ-021 PULSE_I while saturated with a simultaneous launch SHALL be accepted, PEND_O unchanged, OVF_O not set.
REQ-022 OVF_CLR_I SHALL clear OVF_O on the next edge; a simultaneous set SHALL win.
REQ-023 BUSY_O SHALL equal (state == WAIT_ACK) OR (PEND_O != 0), registered-equivalent (derived only from flops).
REQ-024 Events SHALL never be lost or duplicated except by REQ-020 overflow.

Reset
REQ-025 XRST low SHALL immediately force: REQ_TGL_O=0, PEND_O=0, BUSY_O=0, OVF_O=0, state IDLE, all synchronizer flops 0.
REQ-026 Reset mid-handshake SHALL discard pending and in-flight events; the far end SHALL share the same reset assertion so both toggle levels restart at 0.
REQ-027 Release of XRST SHALL be synchronized to CLK outside this block; the block assumes synchronous deassertion.

Structure
REQ-028 State encoding SHALL be a localparam pair (IDLE=0, WAIT_ACK=1) in a shared include PULSE_DEFS.vh, reused by the matching receiver.
REQ-029 The ACK synchronizer SHALL be a separate sub-module SYNC_FF (parameter stage count, async active-low reset, fanout not duplicated).
REQ-030 No other sub-modules; counter and FSM stay in PULSE_SEND.

Verification
REQ-031 Single pulse, far end echoes REQ after 5 CLK: REQ_TGL_O 0->1 two edges after PULSE_I, BUSY_O high until ack_s=1 plus one edge, PEND_O back to 0.
REQ-032 Burst of 6 back-to-back PULSE_I, ack delay 5 CLK: PEND_O peaks at 5, exactly 6 REQ_TGL_O transitions, final REQ_TGL_O=0, OVF_O=0.
REQ-033 P_CNT_W=2, ack withheld, 5 pulses: PEND_O saturates at 3, OVF_O=1; OVF_CLR_I pulse clears it; coincident OVF_CLR_I and drop keeps OVF_O=1.
REQ-034 Spurious ACK_TGL_I toggle while IDLE and PEND_O=0: no REQ_TGL_O change, BUSY_O stays 0.
REQ-035 XRST asserted in WAIT_ACK with PEND_O=3: all outputs 0 immediately; after release, a single new pulse completes normally.
REQ-036 Random pulses and random ack delays 3..20 CLK, 10k cycles: REQ transitions + final PEND_O + dropped count = PULSE_I count.
